sync_fifo_param: RTL and testbench



---
 rtl/sync_fifo_param.sv | 110 +++++++++++
 tb/tb_sync_fifo_param.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with fill level, almost flags, sticky error flags
// and a selectable registered or show-ahead read port.
module sync_fifo_param #(
  parameter int DATA_WIDTH         = 16,
  parameter int LOG2_DEPTH         = 3,
  parameter int SHOWAHEAD          = 0,
  parameter int ALMOST_FULL_LEVEL  = 6,
  parameter int ALMOST_EMPTY_LEVEL = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  read,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [LOG2_DEPTH:0]   level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int PW    = LOG2_DEPTH + 1;
  localparam logic [PW-1:0] AF_LVL = PW'(ALMOST_FULL_LEVEL);
  localparam logic [PW-1:0] AE_LVL = PW'(ALMOST_EMPTY_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  wr_accept;
  logic                  rd_accept;
  logic [DATA_WIDTH-1:0] rd_data;

  // Status flags derive only from registered pointers; the extra pointer bit separates full from empty
  always_comb begin
    level        = wptr_q - rptr_q;
    empty        = (wptr_q == rptr_q);
    full         = (wptr_q[LOG2_DEPTH] != rptr_q[LOG2_DEPTH]) &&
                   (wptr_q[LOG2_DEPTH-1:0] == rptr_q[LOG2_DEPTH-1:0]);
    almost_full  = (level >= AF_LVL);
    almost_empty = (level <= AE_LVL);
    wr_accept    = write & ~full;
    rd_accept    = read & ~empty;
    rd_data      = mem_q[rptr_q[LOG2_DEPTH-1:0]];
    overflow     = ovf_q;
    underflow    = udf_q;
  end

  // Next-state for pointers and sticky error flags; clear wins over any request
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    ovf_d  = ovf_q;
    udf_d  = udf_q;
    if (clear) begin
      wptr_d = {PW{1'b0}};
      rptr_d = {PW{1'b0}};
      ovf_d  = 1'b0;
      udf_d  = 1'b0;
    end else begin
      if (wr_accept) wptr_d = wptr_q + PW'(1);
      else           wptr_d = wptr_q;
      if (rd_accept) rptr_d = rptr_q + PW'(1);
      else           rptr_d = rptr_q;
      ovf_d = ovf_q | (write & full);
      udf_d = udf_q | (read & empty);
    end
  end

  // Pointer and flag state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= {PW{1'b0}};
      rptr_q <= {PW{1'b0}};
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

  // Storage array is intentionally not reset; a write coinciding with clear is dropped
  always_ff @(posedge clock) begin
    if (wr_accept && !clear) mem_q[wptr_q[LOG2_DEPTH-1:0]] <= data_in;
  end

  if (SHOWAHEAD != 0) begin : g_showahead
    assign data_out = rd_data;
  end else begin : g_registered
    logic [DATA_WIDTH-1:0] dout_q;

    // Registered read port holds its value unless a read is accepted
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)                dout_q <= {DATA_WIDTH{1'b0}};
      else if (rd_accept && !clear) dout_q <= rd_data;
    end

    assign data_out = dout_q;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: a registered-read and a show-ahead instance share stimulus
// and are both checked against a queue-based model of the FIFO.
module tb_sync_fifo_param;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear = 1'b0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [15:0] data_in = 16'h0000;

  logic [15:0] dout0, dout1;
  logic        full0, empty0, af0, ae0, ovf0, udf0;
  logic        full1, empty1, af1, ae1, ovf1, udf1;
  logic [3:0]  level0, level1;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model
  logic [15:0] m_q[$];
  logic [15:0] m_dout;
  logic        m_ovf, m_udf;

  always #5 clock = ~clock;

  sync_fifo_param #(.SHOWAHEAD(0)) u_reg (
    .clock(clock), .reset_n(reset_n), .clear(clear), .write(write), .data_in(data_in),
    .read(read), .data_out(dout0), .full(full0), .empty(empty0), .almost_full(af0),
    .almost_empty(ae0), .level(level0), .overflow(ovf0), .underflow(udf0));

  sync_fifo_param #(.SHOWAHEAD(1)) u_sa (
    .clock(clock), .reset_n(reset_n), .clear(clear), .write(write), .data_in(data_in),
    .read(read), .data_out(dout1), .full(full1), .empty(empty1), .almost_full(af1),
    .almost_empty(ae1), .level(level1), .overflow(ovf1), .underflow(udf1));

  wire [9:0] st0 = {full0, empty0, af0, ae0, level0, ovf0, udf0};
  wire [9:0] st1 = {full1, empty1, af1, ae1, level1, ovf1, udf1};

  // Expected status {full, empty, almost_full, almost_empty, level, overflow, underflow}
  function automatic logic [9:0] exp_status();
    int n;
    n = m_q.size();
    return {n == 8, n == 0, n >= 6, n <= 1, 4'(n), m_ovf, m_udf};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_dout = 16'h0000;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  // One clock of stimulus; the model advances at the edge and the task returns at the next falling edge
  task automatic step(input logic w, input logic r, input logic c, input logic [15:0] d);
    logic was_full, was_empty;
    write = w; read = r; clear = c; data_in = d;
    @(posedge clock);
    if (c) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      was_full  = (m_q.size() == 8);
      was_empty = (m_q.size() == 0);
      if (w && was_full)  m_ovf = 1'b1;
      if (r && was_empty) m_udf = 1'b1;
      if (r && !was_empty) m_dout = m_q.pop_front();
      if (w && !was_full) m_q.push_back(d);
    end
    @(negedge clock);
    write = 1'b0; read = 1'b0; clear = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clock);
    tests_run++;
    if (st0 !== 10'b01_0_1_0000_0_0 || dout0 !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_reg: status=%b dout=%h required status=%b dout=0000", st0, dout0, 10'b0101000000);
    end
    tests_run++;
    if (st1 !== 10'b0101000000) begin
      tests_failed++;
      $display("FAIL reset_sa: status=%b required %b", st1, 10'b0101000000);
    end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_fill();
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b0, 1'b0, (i == 8) ? 16'hDEAD : 16'h1000 + 16'(i));
      tests_run++;
      if (st0 !== exp_status() || st1 !== exp_status()) begin
        tests_failed++;
        $display("FAIL fill[%0d]: status reg=%b sa=%b required %b", i, st0, st1, exp_status());
      end
      tests_run++;
      if (dout1 !== 16'h1000) begin
        tests_failed++;
        $display("FAIL fill_head[%0d]: sa dout=%h required 1000", i, dout1);
      end
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 1'b1, 1'b0, 16'h0000);
      tests_run++;
      if (st0 !== exp_status() || st1 !== exp_status()) begin
        tests_failed++;
        $display("FAIL drain[%0d]: status reg=%b sa=%b required %b", i, st0, st1, exp_status());
      end
      tests_run++;
      if (dout0 !== 16'h1000 + 16'(i < 8 ? i : 7) || dout0 !== m_dout) begin
        tests_failed++;
        $display("FAIL drain_data[%0d]: dout=%h required %h", i, dout0, m_dout);
      end
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 16'h2000 + 16'(i));
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 1'b0, 16'($urandom));
      tests_run++;
      if (level0 !== 4'd3 || level1 !== 4'd3 || dout0 !== m_dout || dout1 !== m_q[0]) begin
        tests_failed++;
        $display("FAIL wrap[%0d]: level=%0d/%0d dout=%h/%h required 3 %h/%h",
                 i, level0, level1, dout0, dout1, m_dout, m_q[0]);
      end
    end
  endtask

  task automatic test_showahead();
    step(1'b0, 1'b0, 1'b1, 16'h0000);
    step(1'b1, 1'b0, 1'b0, 16'hA5A5);
    tests_run++;
    if (dout1 !== 16'hA5A5 || empty1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL showahead_head: dout=%h empty=%b required a5a5 0", dout1, empty1);
    end
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    tests_run++;
    if (empty1 !== 1'b1 || st1 !== exp_status() || dout0 !== 16'hA5A5) begin
      tests_failed++;
      $display("FAIL showahead_pop: empty=%b reg dout=%h required 1 a5a5", empty1, dout0);
    end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 16'h4000 + 16'(i));
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 1'b0, 16'h4005);
    step(1'b1, 1'b1, 1'b1, 16'hBEEF);
    tests_run++;
    if (st0 !== 10'b0101000000 || st1 !== 10'b0101000000 || st0 !== exp_status()) begin
      tests_failed++;
      $display("FAIL clear: status reg=%b sa=%b required %b", st0, st1, 10'b0101000000);
    end
    tests_run++;
    if (dout0 !== 16'h4000) begin
      tests_failed++;
      $display("FAIL clear_hold: dout=%h required 4000", dout0);
    end
    // Walk past the slot the discarded write would have used
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 16'h5000 + 16'(i));
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b1, 1'b0, 16'h0000);
      tests_run++;
      if (dout0 !== m_dout) begin
        tests_failed++;
        $display("FAIL clear_nostore[%0d]: dout=%h required %h", i, dout0, m_dout);
      end
    end
    // Asynchronous reset in the middle of a write burst
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 16'h6000 + 16'(i));
    step(1'b1, 1'b1, 1'b0, 16'h6004);
    write = 1'b1; read = 1'b1; data_in = 16'h7777;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    tests_run++;
    if (st0 !== 10'b0101000000 || st1 !== 10'b0101000000 || dout0 !== 16'h0000) begin
      tests_failed++;
      $display("FAIL async_reset: status reg=%b sa=%b dout=%h required %b 0000",
               st0, st1, dout0, 10'b0101000000);
    end
    write = 1'b0; read = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) < 5),
           1'($urandom_range(0, 49) == 0), 16'($urandom));
      tests_run++;
      if (st0 !== exp_status() || st1 !== exp_status() || dout0 !== m_dout) begin
        tests_failed++;
        $display("FAIL random[%0d]: status reg=%b sa=%b dout=%h required %b %h",
                 i, st0, st1, dout0, exp_status(), m_dout);
      end
      if (m_q.size() != 0) begin
        tests_run++;
        if (dout1 !== m_q[0]) begin
          tests_failed++;
          $display("FAIL random_head[%0d]: sa dout=%h required %h", i, dout1, m_q[0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_showahead();
    test_clear();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
